// File: rtl/predictor_pkg.sv
`default_nettype none
// ============================================================================
// Package  : predictor_pkg
// Purpose  : Shared types and helpers for the gshare branch predictor:
//            default index width, 2-bit counter encodings, BTB entry layout
//            and the saturating counter step function.
// Revision : 1.0 - initial release
// ============================================================================
package predictor_pkg;

    localparam int IDX_W_DEFAULT = 5;

    // Tag field is sized for the smallest sensible index (IDX_W = 0) so the
    // struct stays fixed-width; narrower tags are stored zero-extended.
    localparam int TAG_FIELD_W = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,    // strongly not-taken
        WNT = 2'b01,    // weakly not-taken
        WT  = 2'b10,    // weakly taken
        ST  = 2'b11     // strongly taken
    } ctr_e;

    typedef struct packed {
        logic                   valid;
        logic [TAG_FIELD_W-1:0] tag;
        logic [31:0]            target;
        logic                   is_jump;
    } btb_entry_t;

    // One training step of a 2-bit saturating counter.
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = ctr_e'(cur + 2'd1);
            end
        end else begin
            if (cur != SNT) begin
                nxt = ctr_e'(cur - 2'd1);
            end
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_predictor_if.sv
`default_nettype none
// ============================================================================
// Interface : gshare_predictor_if
// Purpose   : Bundles the IF-stage lookup, EX-stage resolution and statistics
//             signals of the gshare predictor.
// Modports  : master - pipeline side (drives PCs and EX outcome)
//             slave  - predictor side (drives predictions, flush, counters)
// Revision  : 1.0 - initial release
// ============================================================================
interface gshare_predictor_if
    import predictor_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT
);
    // IF-stage lookup
    logic [31:0]      current_pc;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;

    // EX-stage resolution
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_pred_pc;
    logic [IDX_W-1:0] ex_pred_idx;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             is_flush;
    logic [31:0]      next_pc;

    // Statistics
    logic [31:0]      branch_count;
    logic [31:0]      mispredict_count;

    modport master (
        output current_pc,
        output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_pred_pc,
        output ex_pred_idx, ex_taken, ex_target,
        input  pred_pc, pred_taken, pred_idx, is_flush, next_pc,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  current_pc,
        input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_pred_pc,
        input  ex_pred_idx, ex_taken, ex_target,
        output pred_pc, pred_taken, pred_idx, is_flush, next_pc,
        output branch_count, mispredict_count
    );

endinterface
`default_nettype wire

// File: rtl/gshare_predictor_sat_counter_table.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter_table
// Purpose  : Pattern history table of 2^IDX_W two-bit saturating counters
//            with one combinational read port and one clocked update port.
//            Reset loads every counter with weakly not-taken.
// Ports    : clk, reset (async, active-low)
//            rd_idx / rd_ctr               - read port (old contents on a
//                                            same-cycle update)
//            upd_en / upd_idx / upd_taken  - train one counter per cycle
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter_table
    import predictor_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [IDX_W-1:0] rd_idx,
    output ctr_e                  rd_ctr,
    input  wire logic             upd_en,
    input  wire logic [IDX_W-1:0] upd_idx,
    input  wire logic             upd_taken
);

    localparam int C_DEPTH = 1 << IDX_W;

    ctr_e ctr_q [C_DEPTH];
    ctr_e ctr_d [C_DEPTH];

    generate
        for (genvar i = 0; i < C_DEPTH; i++) begin : g_entry
            always_comb begin
                ctr_d[i] = ctr_q[i];
                if (upd_en && (upd_idx == IDX_W'(i))) begin
                    ctr_d[i] = ctr_next(ctr_q[i], upd_taken);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ctr_q[i] <= WNT;
                end else begin
                    ctr_q[i] <= ctr_d[i];
                end
            end
        end
    endgenerate

    assign rd_ctr = ctr_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_predictor
// Purpose  : Dynamic next-PC predictor for the 5-stage pipeline. IF lookup
//            combines a direct-mapped BTB with a gshare PHT; EX resolution
//            detects mispredicts, drives the corrected PC and trains the
//            tables. Also keeps resolved-branch and mispredict statistics.
// Ports    : clk            - clock, all state on rising edge
//            reset          - asynchronous, active-low
//            bus (slave)    - lookup, resolution and statistics signals
// Revision : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import predictor_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          reset,
    gshare_predictor_if.slave  bus
);

    localparam int C_DEPTH = 1 << IDX_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    btb_entry_t       btb_q [C_DEPTH];
    btb_entry_t       btb_d [C_DEPTH];
    logic [IDX_W-1:0] bhr_q, bhr_d;
    logic [31:0]      branch_count_q, branch_count_d;
    logic [31:0]      mispredict_count_q, mispredict_count_d;

    // ------------------------------------------------------------------
    // IF-stage lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]       w_btb_idx;
    logic [TAG_FIELD_W-1:0] w_lookup_tag;
    logic [IDX_W-1:0]       w_pred_idx;
    btb_entry_t             w_entry;
    logic                   w_hit;
    ctr_e                   w_pht_ctr;
    logic                   w_pred_taken;
    logic [31:0]            w_pred_pc;

    assign w_btb_idx    = bus.current_pc[IDX_W+1:2];
    assign w_lookup_tag = TAG_FIELD_W'(bus.current_pc[31:IDX_W+2]);
    assign w_pred_idx   = w_btb_idx ^ bhr_q;
    assign w_entry      = btb_q[w_btb_idx];
    assign w_hit        = w_entry.valid && (w_entry.tag == w_lookup_tag);
    // Jumps are always taken once known; branches defer to the PHT MSB.
    assign w_pred_taken = w_hit && (w_entry.is_jump || w_pht_ctr[1]);
    assign w_pred_pc    = w_pred_taken ? w_entry.target : (bus.current_pc + 32'd4);

    // ------------------------------------------------------------------
    // EX-stage resolution
    // ------------------------------------------------------------------
    logic             w_actual_taken;
    logic [31:0]      w_actual_pc;
    logic             w_is_flush;
    logic [IDX_W-1:0] w_ex_btb_idx;
    logic             w_btb_we;
    btb_entry_t       w_btb_wr_entry;
    logic             w_pht_upd;

    assign w_actual_taken = bus.ex_is_jump || bus.ex_taken;
    assign w_actual_pc    = w_actual_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
    // Compare against the PC actually fetched, not the direction bit, so a
    // taken branch with a stale BTB target is also caught.
    assign w_is_flush     = bus.ex_valid && (w_actual_pc != bus.ex_pred_pc);

    assign w_ex_btb_idx   = bus.ex_pc[IDX_W+1:2];
    assign w_btb_we       = bus.ex_valid && w_actual_taken;
    assign w_pht_upd      = bus.ex_valid && bus.ex_is_branch;

    always_comb begin
        w_btb_wr_entry         = '0;
        w_btb_wr_entry.valid   = 1'b1;
        w_btb_wr_entry.tag     = TAG_FIELD_W'(bus.ex_pc[31:IDX_W+2]);
        w_btb_wr_entry.target  = bus.ex_target;
        w_btb_wr_entry.is_jump = bus.ex_is_jump;
    end

    // ------------------------------------------------------------------
    // Pattern history table
    // ------------------------------------------------------------------
    sat_counter_table #(
        .IDX_W     (IDX_W)
    ) u_pht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (w_pred_idx),
        .rd_ctr    (w_pht_ctr),
        .upd_en    (w_pht_upd),
        .upd_idx   (bus.ex_pred_idx),
        .upd_taken (bus.ex_taken)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < C_DEPTH; i++) begin
            btb_d[i] = btb_q[i];
        end
        // A new taken outcome simply replaces whatever aliased there.
        if (w_btb_we) begin
            btb_d[w_ex_btb_idx] = w_btb_wr_entry;
        end
    end

    always_comb begin
        bhr_d = bhr_q;
        if (w_pht_upd) begin
            bhr_d = {bhr_q[IDX_W-2:0], bus.ex_taken};
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bus.ex_valid) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (w_is_flush) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                btb_q[i] <= '0;
            end
            bhr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                btb_q[i] <= btb_d[i];
            end
            bhr_q              <= bhr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pred_pc          = w_pred_pc;
    assign bus.pred_taken       = w_pred_taken;
    assign bus.pred_idx         = w_pred_idx;
    assign bus.is_flush         = w_is_flush;
    assign bus.next_pc          = w_is_flush ? w_actual_pc : w_pred_pc;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_predictor
// Purpose  : Self-checking bench for gshare_predictor. A table-level model
//            (plain arrays indexed by pc/4 mod depth) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

    localparam int IDX_W = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;

    gshare_predictor_if #(.IDX_W(IDX_W)) bus ();

    gshare_predictor #(.IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference tables
    bit          m_valid  [DEPTH];
    int unsigned m_tag    [DEPTH];
    int unsigned m_target [DEPTH];
    bit          m_jump   [DEPTH];
    int          m_pht    [DEPTH];
    int unsigned m_bhr;
    int unsigned m_branches;
    int unsigned m_flushes;

    // Expected values for the current step
    int unsigned e_ppc, e_pidx, e_actual, e_next;
    bit          e_ptaken, e_flush;

    // DUT values captured at the last check point
    logic [31:0] obs_ppc, obs_next;
    logic        obs_flush;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic int unsigned m_index(input int unsigned pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic int unsigned m_tagof(input int unsigned pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_jump[i]   = 0;
            m_pht[i]    = 1;
        end
        m_bhr      = 0;
        m_branches = 0;
        m_flushes  = 0;
    endtask

    task automatic model_predict(input int unsigned pc);
        int unsigned i;
        bit hit;
        i        = m_index(pc);
        e_pidx   = i ^ m_bhr;
        hit      = m_valid[i] && (m_tag[i] == m_tagof(pc));
        e_ptaken = hit && (m_jump[i] || (m_pht[e_pidx] >= 2));
        e_ppc    = e_ptaken ? m_target[i] : pc + 4;
    endtask

    // One cycle: apply inputs, compare all outputs, then advance the model
    // together with the clock edge.
    task automatic step(input logic [31:0] pc, input logic v, input logic br,
                        input logic jmp, input logic [31:0] xpc,
                        input logic [31:0] xpred, input logic [IDX_W-1:0] xidx,
                        input logic xtaken, input logic [31:0] xtgt);
        bit act_taken;
        bus.current_pc   = pc;
        bus.ex_valid     = v;
        bus.ex_is_branch = br;
        bus.ex_is_jump   = jmp;
        bus.ex_pc        = xpc;
        bus.ex_pred_pc   = xpred;
        bus.ex_pred_idx  = xidx;
        bus.ex_taken     = xtaken;
        bus.ex_target    = xtgt;
        #1;
        model_predict(pc);
        act_taken = jmp || xtaken;
        e_actual  = act_taken ? xtgt : xpc + 4;
        e_flush   = v && (e_actual != xpred);
        e_next    = e_flush ? e_actual : e_ppc;

        obs_ppc   = bus.pred_pc;
        obs_next  = bus.next_pc;
        obs_flush = bus.is_flush;
        check("pred_pc",          bus.pred_pc,             e_ppc);
        check("pred_taken",       32'(bus.pred_taken),     32'(e_ptaken));
        check("pred_idx",         32'(bus.pred_idx),       e_pidx);
        check("is_flush",         32'(bus.is_flush),       32'(e_flush));
        check("next_pc",          bus.next_pc,             e_next);
        check("branch_count",     bus.branch_count,        m_branches);
        check("mispredict_count", bus.mispredict_count,    m_flushes);

        if (v && reset) begin
            m_branches++;
            if (e_flush) m_flushes++;
            if (act_taken) begin
                m_valid[m_index(xpc)]  = 1;
                m_tag[m_index(xpc)]    = m_tagof(xpc);
                m_target[m_index(xpc)] = xtgt;
                m_jump[m_index(xpc)]   = jmp;
            end
            if (br) begin
                if (xtaken) m_pht[xidx] = (m_pht[xidx] < 3) ? m_pht[xidx] + 1 : 3;
                else        m_pht[xidx] = (m_pht[xidx] > 0) ? m_pht[xidx] - 1 : 0;
                m_bhr = (m_bhr * 2 + (xtaken ? 1 : 0)) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0, 1'b0, 32'h0);
    endtask

    initial begin : main
        logic [31:0]      saved_ppc;
        logic [IDX_W-1:0] saved_idx;
        logic [31:0]      pc, xpc, xtgt, xpred;
        logic             br, xt, v;
        int unsigned      kind;

        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        fetch(32'h0);
        check("reset_pred_pc", obs_ppc, 32'h4);
        reset = 1'b1;
        fetch(32'h0);

        // Branch 0x10 -> 0x40 taken, fetched as not-taken
        step(32'h0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h14, 5'd4, 1'b1, 32'h40);
        check("first_flush", 32'(obs_flush), 32'd1);
        check("first_next",  obs_next,       32'h40);
        fetch(32'h10);

        // Loop branch 0x20 -> 0x08: 8 taken then exit
        for (int it = 0; it < 9; it++) begin
            fetch(32'h20);
            saved_ppc = e_ppc;
            saved_idx = IDX_W'(e_pidx);
            step(32'h8, 1'b1, 1'b1, 1'b0, 32'h20, saved_ppc, saved_idx, (it < 8), 32'h8);
        end
        check("loop_exit_flush", 32'(obs_flush), 32'd1);
        check("loop_exit_next",  obs_next,       32'h24);

        // jal 0x30 -> 0x100, twice
        for (int k = 0; k < 2; k++) begin
            fetch(32'h30);
            saved_ppc = e_ppc;
            saved_idx = IDX_W'(e_pidx);
            if (k == 1) check("jal_pred_pc", obs_ppc, 32'h100);
            step(32'h100, 1'b1, 1'b0, 1'b1, 32'h30, saved_ppc, saved_idx, 1'b0, 32'h100);
            check("jal_flush", 32'(obs_flush), (k == 0) ? 32'd1 : 32'd0);
        end

        // Tag alias 0x10 / 0x90 evicting each other
        for (int k = 0; k < 4; k++) begin
            pc = (k % 2 == 0) ? 32'h10 : 32'h90;
            fetch(pc);
            saved_ppc = e_ppc;
            saved_idx = IDX_W'(e_pidx);
            if (k >= 1) check("alias_miss", obs_ppc, pc + 32'd4);
            step(32'h0, 1'b1, 1'b1, 1'b0, pc, saved_ppc, saved_idx, 1'b1, 32'h200 + 32'(k * 4));
        end

        // Randomized traffic over 64 PCs (two per BTB set) and a few targets
        for (int n = 0; n < 400; n++) begin
            pc   = 32'($urandom_range(0, 63)) << 2;
            xpc  = 32'($urandom_range(0, 63)) << 2;
            xtgt = 32'($urandom_range(0, 15)) << 4;
            kind = $urandom_range(0, 9);
            v    = (kind != 0);
            br   = (kind < 7);
            xt   = $urandom_range(0, 1) == 1;
            // Half the time the carried prediction is the right one.
            if ($urandom_range(0, 1) == 1) xpred = ((!br) || xt) ? xtgt : xpc + 32'd4;
            else                           xpred = 32'($urandom_range(0, 127)) << 2;
            step(pc, v, v && br, v && !br, xpc, xpred, IDX_W'($urandom_range(0, 31)), xt, xtgt);
        end

        // Asynchronous reset mid-cycle after training
        pc = 32'h30;
        for (int i = 0; i < 64; i++) begin
            model_predict(32'(i) << 2);
            if (e_ptaken) pc = 32'(i) << 2;
        end
        bus.current_pc = pc;
        bus.ex_valid   = 1'b0;
        #1;
        model_predict(pc);
        check("pre_reset_pred_pc", bus.pred_pc, e_ppc);
        reset = 1'b0;
        #1;
        check("async_pred_pc",    bus.pred_pc,             pc + 32'd4);
        check("async_pred_taken", 32'(bus.pred_taken),     32'd0);
        check("async_pred_idx",   32'(bus.pred_idx),       m_index(pc));
        check("async_is_flush",   32'(bus.is_flush),       32'd0);
        check("async_branches",   bus.branch_count,        32'd0);
        check("async_flushes",    bus.mispredict_count,    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        fetch(32'h30);
        fetch(pc);
        step(32'h0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h14, 5'd4, 1'b0, 32'h40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
